// File: rtl/msp430_bb_arb_pkg.sv
// Shared types and helpers for the Blackbone external-port arbiter.
// Consumers: msp430_rr_arbiter and msp430_bb_ext_arbiter.
package msp430_bb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    // Latency counter width; RD_LATENCY is limited to 1..15.
    localparam int CNT_W = $clog2(16);

    // Index width that never collapses to zero for a single requester.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/msp430_rr_arbiter.sv
// Combinational round-robin selector: searches from last+1 upward, wrapping to 0.
// Generic enough to be reused for NoC port or debug-ring sharing.
module msp430_rr_arbiter
    import msp430_bb_arb_pkg::*;
#(
    parameter int N  = 16,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        // i == N wraps back onto last itself, so a lone repeat requester still wins.
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(last) + i) % N);
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/msp430_bb_ext_arbiter.sv
// Serialises per-tile bb_ext requests onto one fixed-latency memory port.
// Optional MSP430_BB_ARB_LOCK_EN: a locking requester keeps the grant for back-to-back accesses.
module msp430_bb_ext_arbiter
    import msp430_bb_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int NODES      = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NODES-1:0][AW-1:0]  req_addr,
    input  logic [NODES-1:0][DW-1:0]  req_din,
    input  logic [NODES-1:0]          req_en,
    input  logic [NODES-1:0]          req_we,
    input  logic [NODES-1:0]          req_lock,
    output logic [NODES-1:0]          ack,
    output logic [DW-1:0]             rdata,
    output logic [AW-1:0]             mem_addr,
    output logic [DW-1:0]             mem_din,
    output logic                      mem_en,
    output logic                      mem_we,
    input  logic [DW-1:0]             mem_dout
);

    localparam int IW = clog2_min1(NODES);

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    last_q, last_d;
    logic [NODES-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    din_q, din_d;
    logic             we_q, we_d;
    logic [DW-1:0]    rdata_q, rdata_d;

    logic [NODES-1:0] rr_gnt;
    logic [IW-1:0]    rr_idx;
    logic [NODES-1:0] sel_oh;
    logic [IW-1:0]    sel_idx;

    msp430_rr_arbiter #(
        .N  (NODES),
        .IW (IW)
    ) u_rr (
        .req     (req_en),
        .last    (last_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

`ifdef MSP430_BB_ARB_LOCK_EN
    logic lock_hit;
    assign lock_hit = req_en[last_q] & req_lock[last_q];
    assign sel_idx  = lock_hit ? last_q : rr_idx;
    assign sel_oh   = lock_hit ? (NODES'(1) << last_q) : rr_gnt;
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign sel_idx     = rr_idx;
    assign sel_oh      = rr_gnt;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (|req_en) begin
                    state_d = ISSUE;
                    last_d  = sel_idx;
                    gnt_d   = sel_oh;
                    addr_d  = req_addr[sel_idx];
                    din_d   = req_din[sel_idx];
                    we_d    = req_we[sel_idx];
                    cnt_d   = CNT_W'(RD_LATENCY);
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Last wait cycle is exactly RD_LATENCY cycles after mem_en.
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d = mem_dout;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= IW'(NODES - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    // Decoded from state so that reset removes strobes in the same cycle.
    assign mem_en   = (state_q == ISSUE);
    assign ack      = (state_q == ACK) ? gnt_q : '0;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign mem_we   = we_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_msp430_bb_ext_arbiter.sv
// Bench for msp430_bb_ext_arbiter: two instances (RD_LATENCY 1 and 3) checked against a
// transaction-schedule model every cycle, plus directed literal expectations.
module tb_msp430_bb_ext_arbiter;

    localparam int N = 4;
`ifdef MSP430_BB_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk;
    logic rst;

    logic [N-1:0][31:0] req_addr [2];
    logic [N-1:0][31:0] req_din  [2];
    logic [N-1:0]       req_en   [2];
    logic [N-1:0]       req_we   [2];
    logic [N-1:0]       req_lock [2];
    logic [N-1:0]       ack      [2];
    logic [31:0]        rdata    [2];
    logic [31:0]        mem_addr [2];
    logic [31:0]        mem_din  [2];
    logic               mem_en   [2];
    logic               mem_we   [2];
    logic [31:0]        mem_dout [2];

    msp430_bb_ext_arbiter #(.AW(32), .DW(32), .NODES(N), .RD_LATENCY(1)) dut0 (
        .clk(clk), .rst(rst),
        .req_addr(req_addr[0]), .req_din(req_din[0]), .req_en(req_en[0]),
        .req_we(req_we[0]), .req_lock(req_lock[0]),
        .ack(ack[0]), .rdata(rdata[0]),
        .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_en(mem_en[0]),
        .mem_we(mem_we[0]), .mem_dout(mem_dout[0])
    );

    msp430_bb_ext_arbiter #(.AW(32), .DW(32), .NODES(N), .RD_LATENCY(3)) dut1 (
        .clk(clk), .rst(rst),
        .req_addr(req_addr[1]), .req_din(req_din[1]), .req_en(req_en[1]),
        .req_we(req_we[1]), .req_lock(req_lock[1]),
        .ack(ack[1]), .rdata(rdata[1]),
        .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_en(mem_en[1]),
        .mem_we(mem_we[1]), .mem_dout(mem_dout[1])
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: each granted request is a schedule of absolute cycle numbers.
    int          lat    [2] = '{1, 3};
    bit          m_busy [2];
    int          m_g    [2];
    int          m_en   [2];
    int          m_ack  [2];
    int          m_free [2];
    int          m_last [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_din  [2];
    logic        m_we   [2];
    logic [31:0] m_rd   [2];

    // Observed issue details, used by the directed checks.
    int          en_cyc  [2];
    logic [31:0] en_addr [2];
    logic [31:0] en_din  [2];
    logic        en_we   [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int k);
        logic [N-1:0] exp_ack;
        bit           exp_en;
        int           g;
        int           j;
        if (rst) begin
            m_busy[k] = 1'b0;
            m_last[k] = N - 1;
            chk($sformatf("rst_mem_en%0d", k), 64'(mem_en[k]), 64'd0);
            chk($sformatf("rst_ack%0d", k), 64'(ack[k]), 64'd0);
            chk($sformatf("rst_rdata%0d", k), 64'(rdata[k]), 64'd0);
            return;
        end
        if (m_busy[k] && cyc >= m_free[k]) m_busy[k] = 1'b0;
        exp_en  = m_busy[k] && (cyc == m_en[k]);
        exp_ack = (m_busy[k] && cyc == m_ack[k]) ? (N'(1) << m_g[k]) : '0;
        if (m_busy[k] && cyc == m_ack[k] - 1) m_rd[k] = mem_dout[k];
        chk($sformatf("mem_en%0d", k), 64'(mem_en[k]), 64'(exp_en));
        chk($sformatf("ack%0d", k), 64'(ack[k]), 64'(exp_ack));
        if (mem_en[k]) begin
            en_cyc[k]  = cyc;
            en_addr[k] = mem_addr[k];
            en_din[k]  = mem_din[k];
            en_we[k]   = mem_we[k];
        end
        if (exp_en) begin
            chk($sformatf("mem_addr%0d", k), 64'(mem_addr[k]), 64'(m_addr[k]));
            chk($sformatf("mem_din%0d", k), 64'(mem_din[k]), 64'(m_din[k]));
            chk($sformatf("mem_we%0d", k), 64'(mem_we[k]), 64'(m_we[k]));
        end
        if (exp_ack != '0)
            chk($sformatf("rdata%0d", k), 64'(rdata[k]), 64'(m_rd[k]));
        if (!m_busy[k]) begin
            g = -1;
            if (LOCK && req_en[k][m_last[k]] && req_lock[k][m_last[k]]) g = m_last[k];
            else begin
                for (int i = 1; i <= N; i++) begin
                    j = (m_last[k] + i) % N;
                    if (g < 0 && req_en[k][j]) g = j;
                end
            end
            if (g >= 0) begin
                m_busy[k] = 1'b1;
                m_g[k]    = g;
                m_last[k] = g;
                m_en[k]   = cyc + 1;
                m_ack[k]  = cyc + 2 + lat[k];
                m_free[k] = cyc + 3 + lat[k];
                m_addr[k] = req_addr[k][g];
                m_din[k]  = req_din[k][g];
                m_we[k]   = req_we[k][g];
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        model_step(0);
        model_step(1);
    end

    // Returns at the negedge of the ack cycle; does not release the request.
    task automatic wait_ack(input int k, input int budget, output int idx, output int tc);
        idx = -1;
        tc  = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack[k] != '0) begin
                for (int n = 0; n < N; n++) if (ack[k][n]) idx = n;
                tc = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL ack_timeout inst%0d: no ack within %0d cycles", k, budget);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int idx;
        int tc;
        int prev;
        int idx2;
        int idx3;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_addr[k] = '0;
            req_din[k]  = '0;
            req_en[k]   = '0;
            req_we[k]   = '0;
            req_lock[k] = '0;
            mem_dout[k] = '0;
            en_cyc[k]   = -1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_addr", 64'(mem_addr[0]), 64'd0);
        chk("reset_mem_din", 64'(mem_din[0]), 64'd0);
        chk("reset_mem_we", 64'(mem_we[0]), 64'd0);
        chk("reset_ack", 64'(ack[0]), 64'd0);
        rst = 1'b0;
        next_cycle();

        // Single read, node 2, latency 1.
        mem_dout[0]    = 32'hDEADBEEF;
        req_addr[0][2] = 32'h100;
        req_we[0][2]   = 1'b0;
        req_en[0][2]   = 1'b1;
        t = cyc;
        wait_ack(0, 20, idx, tc);
        chk("rd_idx", 64'(idx), 64'd2);
        chk("rd_ack_time", 64'(tc), 64'(t + 3));
        chk("rd_en_time", 64'(en_cyc[0]), 64'(t + 1));
        chk("rd_en_addr", 64'(en_addr[0]), 64'h100);
        chk("rd_ack_vec", 64'(ack[0]), 64'b0100);
        chk("rd_rdata", 64'(rdata[0]), 64'hDEADBEEF);
        next_cycle();
        req_en[0][2] = 1'b0;

        // All four request after reset: order 0,1,2,3,0 spaced 4 cycles.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        mem_dout[0] = 32'h5A000000;
        for (int n = 0; n < N; n++) begin
            req_addr[0][n] = 32'h10 * n;
            req_din[0][n]  = 32'h1000 + n;
            req_we[0][n]   = n[0];
        end
        req_en[0] = 4'b1111;
        t = cyc;
        prev = t;
        for (int j = 0; j < 5; j++) begin
            wait_ack(0, 20, idx, tc);
            chk($sformatf("rr_idx%0d", j), 64'(idx), 64'(j % 4));
            if (j == 0) chk("rr_first_time", 64'(tc), 64'(t + 3));
            else chk($sformatf("rr_gap%0d", j), 64'(tc - prev), 64'd4);
            chk($sformatf("rr_rdata%0d", j), 64'(rdata[0]), 64'(32'h5A000000 + j));
            prev = tc;
            next_cycle();
            if (j != 0 && idx >= 0) req_en[0][idx] = 1'b0;
            mem_dout[0] = 32'h5A000000 + j + 1;
        end

        // Reset during WAIT.
        req_addr[0][1] = 32'h44;
        req_en[0][1]   = 1'b1;
        next_cycle();
        chk("rw_issue_en", 64'(mem_en[0]), 64'd1);
        next_cycle();
        rst = 1'b1;
        #1;
        chk("rw_mem_en", 64'(mem_en[0]), 64'd0);
        chk("rw_ack", 64'(ack[0]), 64'd0);
        chk("rw_rdata", 64'(rdata[0]), 64'd0);
        next_cycle();
        req_en[0][0] = 1'b1;
        rst = 1'b0;
        wait_ack(0, 20, idx, tc);
        chk("rw_first_after", 64'(idx), 64'd0);
        next_cycle();
        req_en[0][0] = 1'b0;
        wait_ack(0, 20, idx, tc);
        chk("rw_second_after", 64'(idx), 64'd1);
        next_cycle();
        req_en[0][1] = 1'b0;

        // Write, node 1, latency 3.
        mem_dout[1]    = 32'h12345678;
        req_addr[1][1] = 32'h20;
        req_din[1][1]  = 32'hA5A5A5A5;
        req_we[1][1]   = 1'b1;
        req_en[1][1]   = 1'b1;
        t = cyc;
        wait_ack(1, 30, idx, tc);
        chk("wr_idx", 64'(idx), 64'd1);
        chk("wr_ack_time", 64'(tc), 64'(t + 5));
        chk("wr_en_time", 64'(en_cyc[1]), 64'(t + 1));
        chk("wr_addr", 64'(en_addr[1]), 64'h20);
        chk("wr_din", 64'(en_din[1]), 64'hA5A5A5A5);
        chk("wr_we", 64'(en_we[1]), 64'd1);
        next_cycle();
        req_en[1][1] = 1'b0;
        req_we[1][1] = 1'b0;

        // Lock: node 3 (lock) vs node 0, with last == 1.
        req_addr[1][3] = 32'h300;
        req_lock[1][3] = 1'b1;
        req_en[1][3]   = 1'b1;
        req_addr[1][0] = 32'h0;
        req_en[1][0]   = 1'b1;
        wait_ack(1, 30, idx, tc);
        chk("lk_first", 64'(idx), 64'd3);
        next_cycle();
        req_addr[1][3] = 32'h304;
        wait_ack(1, 30, idx2, tc);
        chk("lk_second", 64'(idx2), LOCK ? 64'd3 : 64'd0);
        next_cycle();
        if (idx2 >= 0) req_en[1][idx2] = 1'b0;
        if (idx2 == 3) req_lock[1][3] = 1'b0;
        wait_ack(1, 30, idx3, tc);
        chk("lk_third", 64'(idx3), LOCK ? 64'd0 : 64'd3);
        next_cycle();
        req_en[1]   = '0;
        req_lock[1] = '0;

        repeat (6) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msp430_bb_ext_arbiter.md
# msp430_bb_ext_arbiter

Shares one external Blackbone memory port among the `NODES` tiles of the MSP430 MPSoC. Each tile's `bb_ext_*` request is serialized with a round-robin arbiter and issued to the single memory port as a one-cycle transaction. A fixed-latency read is waited out, then the tile gets an `ack` pulse with registered read data. The block sits between the per-node `bb_ext_*` buses of `msp430_mpsoc2d/3d/4d` and the off-chip or shared memory controller.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `NODES`, 16, number of requesting tiles (≥1)
- `RD_LATENCY`, 1, cycles from `mem_en` high to valid `mem_dout` (1..15)

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  asynchronous, active-high reset
- `req_addr`  in  [NODES][AW]  per-node address
- `req_din`  in  [NODES][DW]  per-node write data
- `req_en`  in  [NODES]  per-node request; held with addr/din/we stable until ack
- `req_we`  in  [NODES]  1 = write, 0 = read
- `req_lock`  in  [NODES]  keep grant for back-to-back accesses (see Configuration)
- `ack`  out  [NODES]  one-cycle completion pulse, one-hot or zero
- `rdata`  out  DW  read data, valid while any `ack` bit is high
- `mem_addr`  out  AW  shared port address
- `mem_din`  out  DW  shared port write data
- `mem_en`  out  1  shared port enable, one-cycle pulse
- `mem_we`  out  1  shared port write enable, qualified by `mem_en`
- `mem_dout`  in  DW  shared port read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE
  - If any `req_en` is set: select grant index `g` round-robin, searching from `last+1` and wrapping at NODES-1 → 0.
  - Register `mem_addr/din/we` from node `g`, set `last<=g`, `cnt<=RD_LATENCY`, go to ISSUE.
  - If no `req_en` is set: stay in IDLE.
- ISSUE: `mem_en=1` for exactly this cycle, then go to WAIT.
- WAIT: `cnt` decrements each cycle. When `cnt==1`, capture `mem_dout` into `rdata` and go to ACK.
  - Writes use identical timing; `rdata` is captured but meaningless for them.
- ACK: `ack[g]=1` for one cycle, then go to IDLE.
- Requester rule: the requester deasserts `req_en` on the edge that ends its ACK cycle.
- A request withdrawn before its ack still completes. The ack is pulsed and ignored by the requester.
- `mem_addr/din/we` hold their last values outside ISSUE. `mem_we` is only meaningful with `mem_en`.
- `NODES==1`: grant index width is 1 and RR is trivially node 0.
- Reset values: `state=IDLE`, `last=NODES-1` (node 0 wins first), `ack=0`, `rdata=0`, `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_din=0`, `cnt=0`.

## Timing
- Request sampled in IDLE at cycle t.
- `mem_en` is high in cycle t+1.
- `ack` is high in cycle t+2+RD_LATENCY.
- Service time per transaction: RD_LATENCY+3 cycles. With all nodes requesting, each is served once every NODES·(RD_LATENCY+3) cycles.
- No new grant is made in ISSUE, WAIT or ACK. Requests arriving then wait for IDLE.
- Simultaneous requests resolve purely by RR order relative to `last`.
- Reset asserted mid-transaction: all outputs go to reset values immediately. The pending ack is lost and `mem_en` drops the same cycle.

## Configuration
- Macro: `MSP430_BB_ARB_LOCK_EN`.
- Defined: in IDLE, if `req_en[last]` and `req_lock[last]` are both high, `last` is granted again regardless of RR. This lets a node run atomic read-modify-write sequences.
- Undefined: the `req_lock` port exists but is ignored, giving pure round-robin.

## Structure
- Package `msp430_bb_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE, ISSUE, WAIT, ACK)
  - `CNT_W = $clog2(16)`
  - a `clog2_min1` function for grant-index width
- Sub-module `msp430_rr_arbiter`: combinational RR selector.
  - Inputs: `req`, `last`.
  - Outputs: one-hot `gnt` and index `gnt_idx`.
  - Also reusable for NoC and debug-ring sharing.

## Test plan
- Single read, NODES=4, RD_LATENCY=1, node 2 reads 0x100 with `mem_dout`=0xDEADBEEF:
  - `mem_en` is high at t+1.
  - `ack[2]` and `rdata`=0xDEADBEEF at t+3; no other ack bit is high.
- All 4 nodes request simultaneously after reset:
  - Grants go 0,1,2,3,0,… with acks spaced 4 cycles apart (RD_LATENCY=1).
- RD_LATENCY=3, node 1 writes 0xA5A5A5A5 to 0x20:
  - `mem_en`/`mem_we` are high one cycle with the correct addr and data.
  - `ack[1]` comes 5 cycles after sampling.
- Reset asserted in WAIT: `mem_en`, `ack` and `rdata` are 0 immediately. After release, node 0 is granted first.
- With `MSP430_BB_ARB_LOCK_EN`, node 3 requests with lock while node 0 also requests: node 3 is granted twice back-to-back, then node 0. Without the macro, node 0 is granted second.
